// File: rtl/background_scroll.sv
// Scrolling tile background: 3-stage pixel pipeline over shared PMB/NTBL VRAM.
// Build option: define BACKGROUND_TRANSPARENCY_EN to make lightness-0 pixels non-opaque.
module background_scroll #(
    parameter int          NTBL_ROWS = 30,
    parameter int          NTBL_COLS = 32,
    parameter logic [11:0] PMB_BASE  = 12'h200,
    parameter logic [11:0] NTBL_BASE = 12'h400
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic [7:0]  display_x_i,
    input  logic [7:0]  display_y_i,
    input  logic        pixel_valid_i,
    input  logic        frame_start_i,
    output logic [1:0]  r_o,
    output logic [1:0]  g_o,
    output logic [1:0]  b_o,
    output logic        pixel_valid_o,
    output logic        opaque_o,
    input  logic [7:0]  vram_wdata_i,
    output logic [7:0]  vram_rdata_o,
    input  logic [11:0] vram_address_i,
    input  logic        vram_wen_i,
    input  logic        SELECT_pmb_i,
    input  logic        SELECT_ntbl_i,
    input  logic        SELECT_bgreg_i
);

    localparam logic [8:0] WRAP_H = 9'(8 * NTBL_ROWS);

    if (NTBL_COLS != 32) begin : g_bad_cols
        $error("background_scroll: NTBL_COLS must be 32, got %0d", NTBL_COLS);
    end
    if (NTBL_ROWS < 1 || NTBL_ROWS > 32) begin : g_bad_rows
        $error("background_scroll: NTBL_ROWS must be 1..32, got %0d", NTBL_ROWS);
    end

    logic [7:0]  pmb_mem  [512];
    logic [7:0]  ntbl_mem [1024];
    logic [8:0]  pmb_off;
    logic [9:0]  ntbl_off;

    logic [7:0]  scroll_x_pend, scroll_y_pend, scroll_x_q, scroll_y_q;
    logic [5:0]  palette_pend, palette_q;
    logic [7:0]  scroll_y_wr;

    logic [7:0]  vx, vy;
    logic [8:0]  vy_sum;
    logic [9:0]  ntbl_rd_addr;

    logic [7:0]  s1_tile;
    logic [2:0]  s1_intx, s1_inty;
    logic        s1_valid;
    logic [2:0]  s1_px, s1_py;
    logic [8:0]  pmb_rd_addr;

    logic [15:0] s2_line;
    logic [2:0]  s2_px;
    logic        s2_csel;
    logic        s2_valid;
    logic [3:0]  line_idx;
    logic [1:0]  lightness;
    logic [2:0]  colour;

    assign pmb_off  = 9'(vram_address_i - PMB_BASE);
    assign ntbl_off = 10'(vram_address_i - NTBL_BASE);

    // Keep stored scroll_y inside the wrap window so S0 only ever subtracts once.
    assign scroll_y_wr = ({1'b0, vram_wdata_i} >= WRAP_H)
                         ? 8'({1'b0, vram_wdata_i} - WRAP_H) : vram_wdata_i;

    always_comb begin
        vram_rdata_o = 8'h00;
        if (SELECT_pmb_i) begin
            vram_rdata_o = pmb_mem[pmb_off];
        end else if (SELECT_ntbl_i) begin
            vram_rdata_o = ntbl_mem[ntbl_off];
        end else if (SELECT_bgreg_i) begin
            case (vram_address_i[1:0])
                2'd0:    vram_rdata_o = scroll_x_pend;
                2'd1:    vram_rdata_o = scroll_y_pend;
                2'd2:    vram_rdata_o = {2'b00, palette_pend};
                default: vram_rdata_o = 8'h00;
            endcase
        end
    end

    // Pending registers take CPU writes; active copies only move on frame_start_i.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            scroll_x_pend <= 8'h00;
            scroll_y_pend <= 8'h00;
            palette_pend  <= 6'h00;
            scroll_x_q    <= 8'h00;
            scroll_y_q    <= 8'h00;
            palette_q     <= 6'h00;
        end else begin
            if (frame_start_i) begin
                scroll_x_q <= scroll_x_pend;
                scroll_y_q <= scroll_y_pend;
                palette_q  <= palette_pend;
            end
            if (vram_wen_i && SELECT_bgreg_i) begin
                case (vram_address_i[1:0])
                    2'd0:    scroll_x_pend <= vram_wdata_i;
                    2'd1:    scroll_y_pend <= scroll_y_wr;
                    2'd2:    palette_pend  <= vram_wdata_i[5:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (vram_wen_i && SELECT_pmb_i) begin
            pmb_mem[pmb_off] <= vram_wdata_i;
        end
        if (vram_wen_i && SELECT_ntbl_i) begin
            ntbl_mem[ntbl_off] <= vram_wdata_i;
        end
    end

    assign vx           = display_x_i + scroll_x_q;
    assign vy_sum       = {1'b0, display_y_i} + {1'b0, scroll_y_q};
    assign vy           = 8'((vy_sum >= WRAP_H) ? vy_sum - WRAP_H : vy_sum);
    assign ntbl_rd_addr = {vy[7:3], vx[7:3]};

    assign s1_px       = s1_tile[5] ? 3'd7 - s1_intx : s1_intx;
    assign s1_py       = s1_tile[6] ? 3'd7 - s1_inty : s1_inty;
    assign pmb_rd_addr = {s1_tile[4:0], s1_py, 1'b0};

    // Data path registers; synchronous RAM reads see pre-write contents on a collision.
    always_ff @(posedge cpu_clk) begin
        s1_tile <= ntbl_mem[ntbl_rd_addr];
        s1_intx <= vx[2:0];
        s1_inty <= vy[2:0];
        s2_line <= {pmb_mem[pmb_rd_addr], pmb_mem[{pmb_rd_addr[8:1], 1'b1}]};
        s2_px   <= s1_px;
        s2_csel <= s1_tile[7];
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= pixel_valid_i;
            s2_valid <= s1_valid;
        end
    end

    assign line_idx  = {3'd7 - s2_px, 1'b0};
    assign lightness = s2_line[line_idx +: 2];
    assign colour    = s2_csel ? palette_q[5:3] : palette_q[2:0];

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            r_o           <= 2'b00;
            g_o           <= 2'b00;
            b_o           <= 2'b00;
            pixel_valid_o <= 1'b0;
            opaque_o      <= 1'b0;
        end else begin
            r_o           <= s2_valid ? (lightness & {2{colour[2]}}) : 2'b00;
            g_o           <= s2_valid ? (lightness & {2{colour[1]}}) : 2'b00;
            b_o           <= s2_valid ? (lightness & {2{colour[0]}}) : 2'b00;
            pixel_valid_o <= s2_valid;
`ifdef BACKGROUND_TRANSPARENCY_EN
            opaque_o      <= s2_valid && (lightness != 2'b00);
`else
            opaque_o      <= s2_valid;
`endif
        end
    end

endmodule

// File: tb/tb_background_scroll.sv
// Self-checking bench for background_scroll: directed scenarios plus randomized pixels
// checked against a coordinate-arithmetic reference model.
module tb_background_scroll;

    localparam int          ROWS      = 30;
    localparam int          WRAP      = 8 * ROWS;
    localparam logic [11:0] PMB_BASE  = 12'h200;
    localparam logic [11:0] NTBL_BASE = 12'h400;

    logic        cpu_clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  display_x_i = 8'h00;
    logic [7:0]  display_y_i = 8'h00;
    logic        pixel_valid_i = 1'b0;
    logic        frame_start_i = 1'b0;
    logic [1:0]  r_o, g_o, b_o;
    logic        pixel_valid_o;
    logic        opaque_o;
    logic [7:0]  vram_wdata_i = 8'h00;
    logic [7:0]  vram_rdata_o;
    logic [11:0] vram_address_i = 12'h000;
    logic        vram_wen_i = 1'b0;
    logic        SELECT_pmb_i = 1'b0;
    logic        SELECT_ntbl_i = 1'b0;
    logic        SELECT_bgreg_i = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] sh_pmb  [512];
    logic [7:0] sh_ntbl [1024];
    int pend_sx, pend_sy, pend_pal;
    int act_sx, act_sy, act_pal;

    logic [7:0] in_x    [256];
    logic [7:0] in_y    [256];
    logic       in_v    [256];
    logic [7:0] out_pix [256];

    background_scroll #(
        .NTBL_ROWS(ROWS),
        .NTBL_COLS(32),
        .PMB_BASE (PMB_BASE),
        .NTBL_BASE(NTBL_BASE)
    ) dut (
        .cpu_clk       (cpu_clk),
        .rst           (rst),
        .display_x_i   (display_x_i),
        .display_y_i   (display_y_i),
        .pixel_valid_i (pixel_valid_i),
        .frame_start_i (frame_start_i),
        .r_o           (r_o),
        .g_o           (g_o),
        .b_o           (b_o),
        .pixel_valid_o (pixel_valid_o),
        .opaque_o      (opaque_o),
        .vram_wdata_i  (vram_wdata_i),
        .vram_rdata_o  (vram_rdata_o),
        .vram_address_i(vram_address_i),
        .vram_wen_i    (vram_wen_i),
        .SELECT_pmb_i  (SELECT_pmb_i),
        .SELECT_ntbl_i (SELECT_ntbl_i),
        .SELECT_bgreg_i(SELECT_bgreg_i)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    function automatic logic exp_opaque(input int lt);
`ifdef BACKGROUND_TRANSPARENCY_EN
        return lt != 0;
`else
        return 1'b1;
`endif
    endfunction

    // Reference: screen coordinate -> virtual coordinate -> tile -> PMB line -> colour.
    function automatic logic [7:0] model_pixel(input logic [7:0] x, input logic [7:0] y,
                                               input logic v);
        int vx, vy, ix, iy, px, py, base, line, lt, col;
        logic [7:0] tile;
        logic [1:0] r, g, b;
        if (!v) return 8'h00;
        vx = (int'(x) + act_sx) % 256;
        vy = int'(y) + act_sy;
        if (vy >= WRAP) vy = vy - WRAP;
        tile = sh_ntbl[((vy / 8) % 32) * 32 + vx / 8];
        ix = vx % 8;
        iy = vy % 8;
        px = tile[5] ? 7 - ix : ix;
        py = tile[6] ? 7 - iy : iy;
        base = int'(tile[4:0]) * 16 + py * 2;
        line = int'(sh_pmb[base]) * 256 + int'(sh_pmb[base + 1]);
        lt = (line >> (14 - 2 * px)) % 4;
        col = tile[7] ? (act_pal / 8) % 8 : act_pal % 8;
        r = ((col & 4) != 0) ? 2'(lt) : 2'b00;
        g = ((col & 2) != 0) ? 2'(lt) : 2'b00;
        b = ((col & 1) != 0) ? 2'(lt) : 2'b00;
        return {1'b1, exp_opaque(lt), r, g, b};
    endfunction

    task automatic cpu_write(input int sel, input int off, input logic [7:0] data);
        case (sel)
            0:       begin vram_address_i = PMB_BASE + 12'(off);  SELECT_pmb_i = 1'b1;  end
            1:       begin vram_address_i = NTBL_BASE + 12'(off); SELECT_ntbl_i = 1'b1; end
            default: begin vram_address_i = 12'(off);             SELECT_bgreg_i = 1'b1; end
        endcase
        vram_wdata_i = data;
        vram_wen_i = 1'b1;
        tick();
        vram_wen_i = 1'b0;
        SELECT_pmb_i = 1'b0;
        SELECT_ntbl_i = 1'b0;
        SELECT_bgreg_i = 1'b0;
        case (sel)
            0: sh_pmb[off] = data;
            1: sh_ntbl[off] = data;
            default: begin
                if (off == 0) pend_sx = int'(data);
                if (off == 1) pend_sy = (int'(data) >= WRAP) ? int'(data) - WRAP : int'(data);
                if (off == 2) pend_pal = int'(data);
            end
        endcase
    endtask

    task automatic cpu_read(input int sel, input int off, output logic [7:0] data);
        case (sel)
            0:       begin vram_address_i = PMB_BASE + 12'(off);  SELECT_pmb_i = 1'b1;  end
            1:       begin vram_address_i = NTBL_BASE + 12'(off); SELECT_ntbl_i = 1'b1; end
            default: begin vram_address_i = 12'(off);             SELECT_bgreg_i = 1'b1; end
        endcase
        #1;
        data = vram_rdata_o;
        SELECT_pmb_i = 1'b0;
        SELECT_ntbl_i = 1'b0;
        SELECT_bgreg_i = 1'b0;
    endtask

    task automatic commit();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        act_sx = pend_sx;
        act_sy = pend_sy;
        act_pal = pend_pal;
    endtask

    // Drives in_* one pixel per cycle and captures the output 3 cycles later into out_pix.
    task automatic run_stream(input int n);
        for (int j = 0; j < n + 2; j++) begin
            if (j < n) begin
                display_x_i = in_x[j];
                display_y_i = in_y[j];
                pixel_valid_i = in_v[j];
            end else begin
                display_x_i = 8'h00;
                display_y_i = 8'h00;
                pixel_valid_i = 1'b0;
            end
            tick();
            if (j >= 2) out_pix[j - 2] = {pixel_valid_o, opaque_o, r_o, g_o, b_o};
        end
        pixel_valid_i = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            in_x[i] = 8'($urandom);
            in_y[i] = 8'($urandom);
            in_v[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic init_memories();
        for (int i = 0; i < 512; i++) cpu_write(0, i, 8'($urandom));
        for (int i = 0; i < 1024; i++) cpu_write(1, i, 8'($urandom));
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({pixel_valid_o, opaque_o, r_o, g_o, b_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 00",
                     {pixel_valid_o, opaque_o, r_o, g_o, b_o});
        end
        rst = 1'b0;
        pend_sx = 0; pend_sy = 0; pend_pal = 0;
        act_sx = 0;  act_sy = 0;  act_pal = 0;
        for (int k = 0; k < 4; k++) begin
            cpu_read(2, k, rd);
            checks++;
            if (rd !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg%0d got %h expected 00", k, rd);
            end
        end
    endtask

    task automatic test_ram_readback();
        logic [7:0] rd;
        int a;
        for (int k = 0; k < 8; k++) begin
            a = $urandom_range(0, 511);
            cpu_read(0, a, rd);
            checks++;
            if (rd !== sh_pmb[a]) begin
                errors++;
                $display("FAIL pmb_read[%0d] got %h expected %h", a, rd, sh_pmb[a]);
            end
            a = $urandom_range(0, 1023);
            cpu_read(1, a, rd);
            checks++;
            if (rd !== sh_ntbl[a]) begin
                errors++;
                $display("FAIL ntbl_read[%0d] got %h expected %h", a, rd, sh_ntbl[a]);
            end
        end
    endtask

    task automatic test_identity();
        int seq[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
        logic [7:0] expv;
        cpu_write(1, 0, 8'h01);
        cpu_write(0, 16, 8'h1B);
        cpu_write(0, 17, 8'hE4);
        cpu_write(2, 2, 8'h07);
        commit();
        for (int i = 0; i < 8; i++) begin
            in_x[i] = 8'(i);
            in_y[i] = 8'h00;
            in_v[i] = 1'b1;
        end
        run_stream(8);
        for (int i = 0; i < 8; i++) begin
            expv = {1'b1, exp_opaque(seq[i]), 2'(seq[i]), 2'(seq[i]), 2'(seq[i])};
            checks++;
            if (out_pix[i] !== expv) begin
                errors++;
                $display("FAIL identity[%0d] got %h expected %h", i, out_pix[i], expv);
            end
        end
    endtask

    task automatic test_hscroll();
        logic [7:0] expv [2];
        cpu_write(1, 0, 8'h02);
        cpu_write(1, 31, 8'h03);
        cpu_write(0, 32, 8'h55);
        cpu_write(0, 33, 8'h55);
        cpu_write(0, 48, 8'hFF);
        cpu_write(0, 49, 8'hFF);
        cpu_write(2, 0, 8'd250);
        commit();
        in_x[0] = 8'd10; in_y[0] = 8'd0; in_v[0] = 1'b1;
        in_x[1] = 8'd5;  in_y[1] = 8'd0; in_v[1] = 1'b1;
        run_stream(2);
        expv[0] = {1'b1, exp_opaque(1), 2'd1, 2'd1, 2'd1};
        expv[1] = {1'b1, exp_opaque(3), 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_pix[i] !== expv[i]) begin
                errors++;
                $display("FAIL hscroll_wrap[%0d] got %h expected %h", i, out_pix[i], expv[i]);
            end
        end
    endtask

    task automatic test_vscroll();
        logic [7:0] rd;
        logic [7:0] expv [2];
        cpu_write(2, 0, 8'd0);
        cpu_write(2, 1, 8'd250);
        cpu_read(2, 1, rd);
        checks++;
        if (rd !== 8'd10) begin
            errors++;
            $display("FAIL scroll_y_reduce got %0d expected 10", rd);
        end
        commit();
        cpu_write(1, 0, 8'h01);
        cpu_write(0, 26, 8'hC0);
        cpu_write(0, 27, 8'h00);
        in_x[0] = 8'd0; in_y[0] = 8'd235; in_v[0] = 1'b1;
        in_x[1] = 8'd1; in_y[1] = 8'd235; in_v[1] = 1'b1;
        run_stream(2);
        expv[0] = {1'b1, exp_opaque(3), 2'd3, 2'd3, 2'd3};
        expv[1] = {1'b1, exp_opaque(0), 2'd0, 2'd0, 2'd0};
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_pix[i] !== expv[i]) begin
                errors++;
                $display("FAIL vscroll_wrap[%0d] got %h expected %h", i, out_pix[i], expv[i]);
            end
        end
        fill_random(32);
        run_stream(32);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (out_pix[i] !== model_pixel(in_x[i], in_y[i], in_v[i])) begin
                errors++;
                $display("FAIL vscroll_rand[%0d] got %h expected %h", i, out_pix[i],
                         model_pixel(in_x[i], in_y[i], in_v[i]));
            end
        end
    endtask

    task automatic test_double_buffer();
        logic [7:0] rd;
        cpu_write(2, 0, 8'd8);
        fill_random(20);
        run_stream(20);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_pix[i] !== model_pixel(in_x[i], in_y[i], in_v[i])) begin
                errors++;
                $display("FAIL dbuf_pending[%0d] got %h expected %h", i, out_pix[i],
                         model_pixel(in_x[i], in_y[i], in_v[i]));
            end
        end
        // Write and commit in the same cycle: active must take the older pending value.
        vram_address_i = 12'h000;
        SELECT_bgreg_i = 1'b1;
        vram_wdata_i = 8'd16;
        vram_wen_i = 1'b1;
        frame_start_i = 1'b1;
        tick();
        vram_wen_i = 1'b0;
        SELECT_bgreg_i = 1'b0;
        frame_start_i = 1'b0;
        act_sx = pend_sx;
        act_sy = pend_sy;
        act_pal = pend_pal;
        pend_sx = 16;
        cpu_read(2, 0, rd);
        checks++;
        if (rd !== 8'd16) begin
            errors++;
            $display("FAIL dbuf_pending_read got %0d expected 16", rd);
        end
        fill_random(20);
        run_stream(20);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_pix[i] !== model_pixel(in_x[i], in_y[i], in_v[i])) begin
                errors++;
                $display("FAIL dbuf_same_cycle[%0d] got %h expected %h", i, out_pix[i],
                         model_pixel(in_x[i], in_y[i], in_v[i]));
            end
        end
    endtask

    task automatic test_flip();
        int seq[8] = '{3, 2, 1, 0, 0, 3, 2, 1};
        logic [7:0] expv;
        cpu_write(2, 0, 8'd0);
        cpu_write(2, 1, 8'd0);
        cpu_write(2, 2, 8'h38);
        commit();
        cpu_write(1, 0, 8'hE1);
        cpu_write(0, 30, 8'h6C);
        cpu_write(0, 31, 8'h1B);
        for (int i = 0; i < 8; i++) begin
            in_x[i] = 8'(i);
            in_y[i] = 8'h00;
            in_v[i] = 1'b1;
        end
        run_stream(8);
        for (int i = 0; i < 8; i++) begin
            expv = {1'b1, exp_opaque(seq[i]), 2'(seq[i]), 2'(seq[i]), 2'(seq[i])};
            checks++;
            if (out_pix[i] !== expv) begin
                errors++;
                $display("FAIL flip[%0d] got %h expected %h", i, out_pix[i], expv);
            end
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 3; round++) begin
            cpu_write(2, 0, 8'($urandom));
            cpu_write(2, 1, 8'($urandom));
            cpu_write(2, 2, 8'($urandom));
            commit();
            fill_random(64);
            run_stream(64);
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (out_pix[i] !== model_pixel(in_x[i], in_y[i], in_v[i])) begin
                    errors++;
                    $display("FAIL random_r%0d[%0d] got %h expected %h", round, i, out_pix[i],
                             model_pixel(in_x[i], in_y[i], in_v[i]));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] rd;
        int a;
        cpu_write(2, 0, 8'd37);
        cpu_write(2, 2, 8'h3F);
        commit();
        for (int k = 0; k < 2; k++) begin
            display_x_i = 8'($urandom);
            display_y_i = 8'($urandom);
            pixel_valid_i = 1'b1;
            tick();
        end
        display_x_i = 8'($urandom);
        pixel_valid_i = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pixel_valid_i = 1'b0;
        pend_sx = 0; pend_sy = 0; pend_pal = 0;
        act_sx = 0;  act_sy = 0;  act_pal = 0;
        checks++;
        if ({pixel_valid_o, opaque_o, r_o, g_o, b_o} !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs got %h expected 00",
                     {pixel_valid_o, opaque_o, r_o, g_o, b_o});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pixel_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL midreset_drop[%0d] got %b expected 0", k, pixel_valid_o);
            end
        end
        cpu_read(2, 0, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL midreset_scroll_x got %h expected 00", rd);
        end
        for (int k = 0; k < 4; k++) begin
            a = $urandom_range(0, 1023);
            cpu_read(1, a, rd);
            checks++;
            if (rd !== sh_ntbl[a]) begin
                errors++;
                $display("FAIL midreset_ram[%0d] got %h expected %h", a, rd, sh_ntbl[a]);
            end
        end
        cpu_write(2, 2, 8'h3F);
        commit();
        fill_random(16);
        run_stream(16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_pix[i] !== model_pixel(in_x[i], in_y[i], in_v[i])) begin
                errors++;
                $display("FAIL midreset_resume[%0d] got %h expected %h", i, out_pix[i],
                         model_pixel(in_x[i], in_y[i], in_v[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        init_memories();
        test_ram_readback();
        test_identity();
        test_hscroll();
        test_vscroll();
        test_double_buffer();
        test_flip();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
